// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, LSB-first data,
// optional parity, then one or two stop bits, paced by baud_tick.
module uart_tx_serializer #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_BITS - 1);
  localparam logic SLAST = (STOP_BITS == 2);
  localparam logic ODD = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE, ARM, START, DATA, PARITY, STOP
  } state_t;

  state_t               state, state_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic                 par, par_n;
  logic                 scnt, scnt_n;
  logic                 tx_n, busy_n, done_n;

  // State and registered outputs; reset abandons any frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      par   <= 1'b0;
      scnt  <= 1'b0;
      tx    <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      cnt   <= cnt_n;
      par   <= par_n;
      scnt  <= scnt_n;
      tx    <= tx_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

  // Next state and next output values; every move waits on a tick.
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n   = cnt;
    par_n   = par;
    scnt_n  = scnt;
    tx_n    = tx;
    busy_n  = busy;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
        if (tx_start) begin
          shreg_n = tx_data;
          par_n   = 1'b0;
          cnt_n   = '0;
          scnt_n  = 1'b0;
          busy_n  = 1'b1;
          state_n = ARM;
        end
      end
      ARM: begin
        if (baud_tick) begin
          state_n = START;
          tx_n    = 1'b0;
        end
      end
      START: begin
        if (baud_tick) begin
          state_n = DATA;
          tx_n    = shreg[0];
        end
      end
      DATA: begin
        if (baud_tick) begin
          par_n   = par ^ shreg[0];
          shreg_n = {1'b0, shreg[DATA_BITS-1:1]};
          cnt_n   = cnt + CW'(1);
          if (cnt == LAST) begin
            if (PARITY_EN != 0) begin
              state_n = PARITY;
              tx_n    = par ^ shreg[0] ^ ODD;
            end else begin
              state_n = STOP;
              tx_n    = 1'b1;
            end
          end else begin
            tx_n = shreg[1];
          end
        end
      end
      PARITY: begin
        if (baud_tick) begin
          state_n = STOP;
          tx_n    = 1'b1;
        end
      end
      STOP: begin
        if (baud_tick) begin
          if (scnt == SLAST) begin
            state_n = IDLE;
            done_n  = 1'b1;
            busy_n  = 1'b0;
            tx_n    = 1'b1;
            scnt_n  = 1'b0;
          end else begin
            scnt_n = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: three parameterisations,
// frames decoded from tx and matched against a queue of expected bytes.
module tb_uart_tx_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       baud_tick;
  logic [2:0] sv;
  logic [7:0] dv [3];
  wire  [2:0] txv, bv, dnv;

  uart_tx_serializer u0 (
    .clk(clk), .reset(reset), .baud_tick(baud_tick),
    .tx_start(sv[0]), .tx_data(dv[0]),
    .tx(txv[0]), .busy(bv[0]), .done(dnv[0])
  );

  uart_tx_serializer #(.PARITY_EN(1), .STOP_BITS(2)) u1 (
    .clk(clk), .reset(reset), .baud_tick(baud_tick),
    .tx_start(sv[1]), .tx_data(dv[1]),
    .tx(txv[1]), .busy(bv[1]), .done(dnv[1])
  );

  uart_tx_serializer #(.PARITY_EN(1), .PARITY_ODD(1)) u2 (
    .clk(clk), .reset(reset), .baud_tick(baud_tick),
    .tx_start(sv[2]), .tx_data(dv[2]),
    .tx(txv[2]), .busy(bv[2]), .done(dnv[2])
  );

  typedef struct packed {
    logic [7:0] d;
    logic       p;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int errors = 0;
  int checks = 0;
  int tick_period = 16;
  int dcnt[3] = '{0, 0, 0};
  int pen[3] = '{0, 1, 1};
  int nst[3] = '{1, 2, 1};
  logic tk = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int i, input logic [7:0] d, input logic p);
    exp_t e;
    e.d = d;
    e.p = p;
    case (i)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic end_frame(input int i, input logic [7:0] d,
                           input logic p);
    exp_t e;
    bit ok;
    ok = 1'b1;
    case (i)
      0: if (q0.size() > 0) e = q0.pop_front(); else ok = 1'b0;
      1: if (q1.size() > 0) e = q1.pop_front(); else ok = 1'b0;
      default: if (q2.size() > 0) e = q2.pop_front(); else ok = 1'b0;
    endcase
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL unexpected frame u%0d: got %0h expected none", i, d);
    end else begin
      chk($sformatf("frame data u%0d", i), {24'd0, d}, {24'd0, e.d});
      if (pen[i] == 1)
        chk($sformatf("parity u%0d", i), {31'd0, p}, {31'd0, e.p});
    end
  endtask

  // Baud strobe source, updated away from the rising edge.
  initial begin
    int tcnt;
    tcnt = 0;
    baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (tcnt + 1 >= tick_period) begin
        baud_tick = 1'b1;
        tcnt = 0;
      end else begin
        baud_tick = 1'b0;
        tcnt++;
      end
    end
  end

  always @(posedge clk) tk <= baud_tick;

  // Frame decoder: one sample per tick, one bit per sample.
  initial begin
    int   mst[3];
    int   mcnt[3];
    logic [7:0] mdat[3];
    logic mpar[3];
    for (int i = 0; i < 3; i++) begin
      mst[i] = 0; mcnt[i] = 0; mdat[i] = '0; mpar[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      if (reset) begin
        for (int i = 0; i < 3; i++) mst[i] = 0;
      end else if (tk) begin
        for (int i = 0; i < 3; i++) begin
          if (mst[i] == 0) begin
            if (txv[i] == 1'b0) begin
              mst[i] = 1;
              mcnt[i] = 0;
              chk($sformatf("start busy u%0d", i), {31'd0, bv[i]}, 1);
            end
          end else begin
            if (mcnt[i] < 8) begin
              mdat[i][mcnt[i]] = txv[i];
            end else if (pen[i] == 1 && mcnt[i] == 8) begin
              mpar[i] = txv[i];
            end else if (mcnt[i] < 8 + pen[i] + nst[i]) begin
              chk($sformatf("stop bit u%0d", i), {31'd0, txv[i]}, 1);
              chk($sformatf("stop busy/done u%0d", i),
                  {30'd0, bv[i], dnv[i]}, 2);
            end else begin
              chk($sformatf("end busy/done u%0d", i),
                  {30'd0, bv[i], dnv[i]}, 1);
              end_frame(i, mdat[i], mpar[i]);
              mst[i] = 0;
            end
            mcnt[i]++;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++)
        if (dnv[i] === 1'b1) dcnt[i]++;
    end
  end

  task automatic send(input int i, input logic [7:0] d);
    int n;
    n = 0;
    while (bv[i] !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("send timeout", 1, 0);
    sv[i] = 1'b1;
    dv[i] = d;
    @(negedge clk);
    sv[i] = 1'b0;
  endtask

  task automatic wait_tx0(input int i);
    int n;
    n = 0;
    while (txv[i] !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("start bit timeout", 1, 0);
  endtask

  task automatic wait_done(input int i);
    int n;
    n = 0;
    while (dnv[i] !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("done timeout", 1, 0);
  endtask

  task automatic wait_busy(input int i, input logic v);
    int n;
    n = 0;
    while (bv[i] !== v && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("busy timeout", 1, 0);
  endtask

  task automatic measure(input int i, input int exp, input string nm);
    int n;
    wait_tx0(i);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dnv[i] !== 1'b1 && n < 3000);
    chk(nm, n, exp);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0;
    reset = 1'b1;
    sv = 3'b000;
    for (int i = 0; i < 3; i++) dv[i] = 8'h00;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++)
      chk($sformatf("reset tx/busy/done u%0d", i),
          {29'd0, txv[i], bv[i], dnv[i]}, 3'b100);
    #2 reset = 1'b0;
    repeat (20) @(negedge clk);

    // 0x55 default framing, 16-cycle bits
    push(0, 8'h55, 1'b0);
    send(0, 8'h55);
    chk("busy after accept", {31'd0, bv[0]}, 1);
    measure(0, 160, "frame length 0x55");

    // parity, even with two stop bits, then odd
    push(1, 8'h01, 1'b1);
    send(1, 8'h01);
    measure(1, 192, "frame length 2 stop");
    push(1, 8'hA3, 1'b0);
    send(1, 8'hA3);
    wait_done(1);
    push(2, 8'h01, 1'b0);
    send(2, 8'h01);
    wait_done(2);

    // start request while busy is dropped
    push(0, 8'h12, 1'b0);
    send(0, 8'h12);
    repeat (50) @(negedge clk);
    sv[0] = 1'b1;
    dv[0] = 8'hFF;
    @(negedge clk);
    sv[0] = 1'b0;
    chk("busy during ignored start", {31'd0, bv[0]}, 1);
    wait_done(0);

    // held start gives back-to-back frames
    d0 = dcnt[0];
    push(0, 8'h12, 1'b0);
    push(0, 8'h34, 1'b0);
    sv[0] = 1'b1;
    dv[0] = 8'h12;
    wait_busy(0, 1'b1);
    dv[0] = 8'h34;
    wait_busy(0, 1'b0);
    @(negedge clk);
    chk("b2b reaccept busy", {31'd0, bv[0]}, 1);
    sv[0] = 1'b0;
    wait_done(0);
    @(negedge clk);
    chk("b2b done pulses", dcnt[0] - d0, 2);

    // asynchronous reset during data bit 3
    send(0, 8'hC3);
    wait_tx0(0);
    repeat (69) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async reset tx/busy/done", {29'd0, txv[0], bv[0], dnv[0]}, 3'b100);
    @(negedge clk);
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    push(0, 8'h0F, 1'b0);
    send(0, 8'h0F);
    wait_done(0);

    // tick every cycle, including the acceptance cycle
    tick_period = 1;
    repeat (3) @(negedge clk);
    push(0, 8'h3C, 1'b0);
    send(0, 8'h3C);
    chk("arm holds tx high", {31'd0, txv[0]}, 1);
    measure(0, 10, "frame length fast tick");

    repeat (20) @(negedge clk);
    chk("u0 queue drained", q0.size(), 0);
    chk("u1 queue drained", q1.size(), 0);
    chk("u2 queue drained", q2.size(), 0);
    chk("u0 done count", dcnt[0], 6);
    chk("u1 done count", dcnt[1], 2);
    chk("u2 done count", dcnt[2], 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
